data_sram_slave: RTL and testbench

//   Responder end of the CPU data SRAM interface (en/wen/addr/wdata -> rdata). Sits outside

---
 rtl/data_sram_slave.sv | 119 +++++++++++
 tb/tb_data_sram_slave.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_slave.sv
// Responder for the CPU data SRAM port: a word RAM plus a small config-register window.
// Optional macro CONF_TIMER_EN adds a free-running 32-bit timer at offset 16'he000.
module data_sram_slave #(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] CONF_BASE = 32'hbfaf_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic [31:0] num_data
);

    localparam logic [15:0] OFF_LED    = 16'hf000;
    localparam logic [15:0] OFF_NUM    = 16'hf010;
    localparam logic [15:0] OFF_SWITCH = 16'hf020;
    localparam logic [15:0] OFF_TIMER  = 16'he000;

    logic [31:0]       r_ram [0:(2**ADDR_W)-1];
    logic [31:0]       r_rdata;
    logic [15:0]       r_led;
    logic [31:0]       r_num;
    logic [7:0]        r_sw_meta;
    logic [7:0]        r_sw_sync;

    logic              w_conf_hit;
    logic              w_ram_sel;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_idx;
    logic [15:0]       w_off;
    logic [31:0]       w_mask;
    logic [31:0]       w_conf_rdata;
    logic [31:0]       w_timer_rd;

    assign w_conf_hit = data_sram_en && (data_sram_addr[31:16] == CONF_BASE[31:16]);
    assign w_ram_sel  = data_sram_en && !w_conf_hit;
    assign w_ram_we   = w_ram_sel && resetn;
    assign w_idx      = data_sram_addr[ADDR_W+1:2];
    assign w_off      = data_sram_addr[15:0];
    assign w_mask     = {{8{data_sram_wen[3]}}, {8{data_sram_wen[2]}},
                         {8{data_sram_wen[1]}}, {8{data_sram_wen[0]}}};

`ifdef CONF_TIMER_EN
    logic [31:0] r_timer;
    logic [31:0] w_timer_inc;

    assign w_timer_inc = r_timer + 32'd1;
    assign w_timer_rd  = r_timer;

    // Written lanes take wdata; unwritten lanes still advance with the increment.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_timer <= '0;
        end else if (w_conf_hit && (w_off == OFF_TIMER)) begin
            r_timer <= (w_timer_inc & ~w_mask) | (data_sram_wdata & w_mask);
        end else begin
            r_timer <= w_timer_inc;
        end
    end
`else
    assign w_timer_rd = '0;
`endif

    always_comb begin
        w_conf_rdata = '0;
        case (w_off)
            OFF_LED:    w_conf_rdata = {16'h0000, r_led};
            OFF_NUM:    w_conf_rdata = r_num;
            OFF_SWITCH: w_conf_rdata = {24'h0, r_sw_sync};
            OFF_TIMER:  w_conf_rdata = w_timer_rd;
            default:    w_conf_rdata = '0;
        endcase
    end

    // RAM is left unreset so it can map onto block memory.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) begin
                    r_ram[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rdata   <= '0;
            r_led     <= '0;
            r_num     <= '0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= switch;
            r_sw_sync <= r_sw_meta;
            if (w_ram_sel) begin
                r_rdata <= r_ram[w_idx];
            end else if (w_conf_hit) begin
                r_rdata <= w_conf_rdata;
            end
            if (w_conf_hit && (w_off == OFF_LED)) begin
                r_led <= (r_led & ~w_mask[15:0]) | (data_sram_wdata[15:0] & w_mask[15:0]);
            end
            if (w_conf_hit && (w_off == OFF_NUM)) begin
                r_num <= (r_num & ~w_mask) | (data_sram_wdata & w_mask);
            end
        end
    end

    assign data_sram_rdata = r_rdata;
    assign led             = r_led;
    assign num_data        = r_num;

endmodule

// File: tb/tb_data_sram_slave.sv
// Directed bench for data_sram_slave: transaction-level model checked every cycle,
// plus literal expectations from hand-worked scenarios.
module tb_data_sram_slave;

    logic        clk;
    logic        resetn;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  switch;
    logic [15:0] led;
    logic [31:0] num_data;

    int vectors;
    int miscompares;

    data_sram_slave dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .switch          (switch),
        .led             (led),
        .num_data        (num_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state
    logic [31:0] m_mem [int];
    logic [31:0] e_rdata;
    bit          e_valid;
    logic [15:0] e_led;
    logic [31:0] e_num;
    logic [31:0] e_timer;
    logic [7:0]  m_sw_first;
    logic [7:0]  m_sw_second;
    logic [7:0]  sw_drv;
    bit          chk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] lanes);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (lanes[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies the rules of one clock edge to the model using the inputs held at that edge.
    task automatic model_edge();
        logic [31:0] rd;
        bit          rv;
        int          idx;
        bit          timer_wr;
        rd = '0;
        rv = 1'b1;
        timer_wr = 1'b0;
        if (!resetn) begin
            e_rdata = '0; e_valid = 1'b1; e_led = '0; e_num = '0; e_timer = '0;
            m_sw_first = '0; m_sw_second = '0;
            return;
        end
        if (en) begin
            if (addr[31:16] == 16'hbfaf) begin
                case (addr[15:0])
                    16'hf000: rd = {16'h0, e_led};
                    16'hf010: rd = e_num;
                    16'hf020: rd = {24'h0, m_sw_second};
`ifdef CONF_TIMER_EN
                    16'he000: begin rd = e_timer; timer_wr = 1'b1; end
`endif
                    default:  rd = '0;
                endcase
                if (addr[15:0] == 16'hf000) e_led = merge({16'h0, e_led}, wdata, wen) & 32'hffff;
                if (addr[15:0] == 16'hf010) e_num = merge(e_num, wdata, wen);
            end else begin
                idx = int'(addr[13:2]);
                if (m_mem.exists(idx)) rd = m_mem[idx];
                else rd = 32'hxxxx_xxxx;
                rv = !$isunknown(rd);
                if (wen != 4'h0) m_mem[idx] = merge(rd, wdata, wen);
            end
            e_rdata = rd;
            e_valid = rv;
        end
`ifdef CONF_TIMER_EN
        if (timer_wr) e_timer = merge(e_timer + 32'd1, wdata, wen);
        else e_timer = e_timer + 32'd1;
`endif
        m_sw_second = m_sw_first;
        m_sw_first  = switch;
    endtask

    always @(negedge clk) begin
        if (chk) begin
            if (e_valid) check("rdata", rdata, e_rdata);
            check("led", {16'h0, led}, {16'h0, e_led});
            check("num_data", num_data, e_num);
        end
    end

    task automatic step(input bit rst, input bit e, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        resetn = rst; en = e; wen = w; addr = a; wdata = d; switch = sw_drv;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        step(1'b1, 1'b1, w, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b1, 1'b1, 4'h0, a, 32'h0);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        vectors = 0; miscompares = 0; chk = 1'b0;
        resetn = 1'b0; en = 1'b0; wen = 4'h0; addr = '0; wdata = '0;
        sw_drv = 8'h00; switch = 8'h00;
        e_rdata = '0; e_valid = 1'b0; e_led = '0; e_num = '0; e_timer = '0;
        m_sw_first = '0; m_sw_second = '0;

        // Reset for two cycles
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        chk = 1'b1;
        step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_led", {16'h0, led}, 32'h0);
        check("reset_num", num_data, 32'h0);
        check("reset_no_x", {31'h0, $isunknown({rdata, led, num_data})}, 32'h0);

        // Full write, read back, lane write with read-first, reread
        wr(32'h0000_0010, 4'hf, 32'h1234_5678);
        rd(32'h0000_0010);
        check("ram_read_full", rdata, 32'h1234_5678);
        wr(32'h0000_0010, 4'b0010, 32'haabb_ccdd);
        check("ram_read_first", rdata, 32'h1234_5678);
        rd(32'h0000_0010);
        check("ram_lane_write", rdata, 32'h1234_cc78);

        // en=0: rdata holds and wen is ignored
        step(1'b1, 1'b0, 4'hf, 32'h0000_0010, 32'h0bad_0bad);
        check("hold_rdata", rdata, 32'h1234_cc78);
        rd(32'h0000_0010);
        check("wen_ignored", rdata, 32'h1234_cc78);

        // Aliasing: 0x10010, 0x4010 and 0x10 all map to word index 4
        wr(32'h0001_0010, 4'hf, 32'hdead_beef);
        rd(32'h0000_4010);
        check("alias_4010", rdata, 32'hdead_beef);
        rd(32'h0000_0010);
        check("alias_0010", rdata, 32'hdead_beef);

        // Config window
        wr(32'hbfaf_f000, 4'hf, 32'hffff_a5a5);
        check("led_write", {16'h0, led}, 32'h0000_a5a5);
        rd(32'hbfaf_f000);
        check("led_read", rdata, 32'h0000_a5a5);
        wr(32'hbfaf_f010, 4'hf, 32'h0000_0007);
        check("num_write", num_data, 32'h0000_0007);
        wr(32'hbfaf_f000, 4'b0010, 32'h0000_3c00);
        check("led_lane", {16'h0, led}, 32'h0000_3ca5);
        wr(32'hbfaf_f030, 4'hf, 32'h5555_5555);
        rd(32'hbfaf_f030);
        check("unmapped_read", rdata, 32'h0);
        wr(32'hbfaf_f020, 4'hf, 32'hffff_ffff);
        rd(32'hbfaf_f020);
        check("switch_ro", rdata, 32'h0);

        // Switch synchronizer
        sw_drv = 8'h3c;
        idle(); idle(); idle();
        rd(32'hbfaf_f020);
        check("switch_steady", rdata, 32'h0000_003c);
        sw_drv = 8'hc3;
        idle();
        rd(32'hbfaf_f020);
        check("switch_late", rdata, 32'h0000_003c);
        rd(32'hbfaf_f020);
        check("switch_next", rdata, 32'h0000_00c3);

        // Timer
        wr(32'hbfaf_e000, 4'hf, 32'hffff_fffe);
        idle();
        rd(32'hbfaf_e000);
`ifdef CONF_TIMER_EN
        check("timer_value", rdata, 32'hffff_ffff);
        rd(32'hbfaf_e000);
        check("timer_wrap", rdata, 32'h0000_0000);
        wr(32'hbfaf_e000, 4'b0001, 32'h0000_0010);
        rd(32'hbfaf_e000);
        check("timer_lane", rdata, 32'h0000_0010);
`else
        check("timer_off", rdata, 32'h0);
        rd(32'hbfaf_e000);
        check("timer_off2", rdata, 32'h0);
`endif

        // Reset during a read drops it; RAM survives reset
        rd(32'h0000_0010);
        check("pre_reset_read", rdata, 32'hdead_beef);
        step(1'b0, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
        check("reset_drop_read", rdata, 32'h0);
        check("reset_led2", {16'h0, led}, 32'h0);
        check("reset_num2", num_data, 32'h0);
        rd(32'h0000_0010);
        check("ram_kept", rdata, 32'hdead_beef);
        idle();

        @(negedge clk);
        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
